// File: rtl/bridge_pkg.sv
// Shared definitions for the M-stage memory-mapped bridge: control-window
// offsets, default device geometry, region select and the error bit index.
package bridge_pkg;

    localparam logic [31:0] BRG_PEND_OFF   = 32'h0;
    localparam logic [31:0] BRG_MASK_OFF   = 32'h4;
    localparam logic [31:0] BRG_ERR_OFF    = 32'h8;
    localparam logic [31:0] BRG_SPAN       = 32'd12;
    localparam logic [31:0] DEF_DEV_STRIDE = 32'h10;
    localparam int          DEF_DEV_SPAN   = 12;
    localparam int          ERR_BIT        = 31;

    typedef enum logic [1:0] {
        REG_DM   = 2'd0,
        REG_DEV  = 2'd1,
        REG_BRG  = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    // Written as a - base < span so a window ending at the top of the
    // address space does not wrap.
    function automatic logic in_window(input logic [31:0] a,
                                       input logic [31:0] base,
                                       input logic [31:0] span);
        return (a >= base) && ((a - base) < span);
    endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// One interrupt channel: rising-edge detect against the previous-cycle sample
// feeding a sticky pending bit with write-1-to-clear; a new edge beats a clear.
module irq_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic clr,
    output logic pend
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
            pend <= 1'b0;
        end else begin
            prev <= level;
            if (level && !prev)
                pend <= 1'b1;
            else if (clr)
                pend <= 1'b0;
        end
    end

endmodule

// File: rtl/sys_bridge_n.sv
// M-stage bridge to data memory, N_DEV device windows and a control window.
// Optional build macro BRIDGE_ERR_EN enables unmapped/partial-store fault capture.
module sys_bridge_n
    import bridge_pkg::*;
#(
    parameter int          N_DEV      = 2,
    parameter logic [31:0] DEV_BASE   = 32'h7f00,
    parameter logic [31:0] DEV_STRIDE = DEF_DEV_STRIDE,
    parameter int          DEV_SPAN   = DEF_DEV_SPAN,
    parameter logic [31:0] DM_LAST    = 32'h2fff
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic [31:0]          addr,
    input  logic [3:0]           byteen,
    input  logic [31:0]          wdata,
    input  logic [31:0]          dm_rdata,
    input  logic [32*N_DEV-1:0]  dev_rdata,
    input  logic [N_DEV-1:0]     dev_irq,
    output logic [3:0]           dm_we,
    output logic [N_DEV-1:0]     dev_we,
    output logic [31:0]          dev_addr,
    output logic [31:0]          dev_wdata,
    output logic [31:0]          rdata,
    output logic                 rd_valid,
    output logic                 irq
);

    localparam logic [31:0] BRG_BASE = DEV_BASE + DEV_STRIDE * 32'(N_DEV);

    // Handshake: req qualifies addr/byteen/wdata for exactly one cycle and is
    // never stalled. Stores strobe combinationally in the req cycle; a load
    // (byteen == 0) returns rdata with rd_valid high exactly one cycle later.

    region_e            region;
    logic [N_DEV-1:0]   dev_hit;
    logic [31:0]        dev_sel_rdata;
    logic [31:0]        brg_off;
    logic               is_load;
    logic               is_full;
    logic               wr_ok;
    logic               brg_wr;
    logic [N_DEV-1:0]   pend;
    logic [N_DEV-1:0]   pend_clr;
    logic [N_DEV-1:0]   mask;
    logic               err_flag;
    logic [31:0]        err_addr;
    logic [31:0]        pend_word;
    logic [31:0]        rd_mux;

    always_comb begin
        region        = REG_NONE;
        dev_hit       = '0;
        dev_sel_rdata = '0;
        if (addr <= DM_LAST) begin
            region = REG_DM;
        end else if (in_window(addr, BRG_BASE, BRG_SPAN)) begin
            region = REG_BRG;
        end else begin
            for (int k = 0; k < N_DEV; k++) begin
                if (in_window(addr, DEV_BASE + DEV_STRIDE * 32'(k), 32'(DEV_SPAN))) begin
                    region        = REG_DEV;
                    dev_hit[k]    = 1'b1;
                    dev_sel_rdata = dev_rdata[32*k +: 32];
                end
            end
        end
    end

    assign brg_off   = addr - BRG_BASE;
    assign is_load   = (byteen == 4'h0);
    assign is_full   = (byteen == 4'hf);
    assign wr_ok     = req && !reset && is_full;
    assign brg_wr    = wr_ok && (region == REG_BRG);

    assign dm_we     = (req && !reset && region == REG_DM) ? byteen : 4'h0;
    assign dev_we    = (wr_ok && region == REG_DEV) ? dev_hit : '0;
    assign dev_addr  = addr;
    assign dev_wdata = wdata;

    assign pend_clr  = (brg_wr && brg_off == BRG_PEND_OFF) ? wdata[N_DEV-1:0] : '0;

    for (genvar k = 0; k < N_DEV; k++) begin : g_irq
        irq_edge_latch u_latch (
            .clk   (clk),
            .reset (reset),
            .level (dev_irq[k]),
            .clr   (pend_clr[k]),
            .pend  (pend[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)
            mask <= '0;
        else if (brg_wr && brg_off == BRG_MASK_OFF)
            mask <= wdata[N_DEV-1:0];
    end

`ifdef BRIDGE_ERR_EN
    logic fault;
    logic err_clr;

    // Partial stores only fault inside device/control windows; DM takes any byteen.
    assign fault   = req && !reset &&
                     ((region == REG_NONE) ||
                      ((region == REG_DEV || region == REG_BRG) && !is_load && !is_full));
    assign err_clr = brg_wr && (brg_off == BRG_PEND_OFF) && wdata[ERR_BIT];

    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag <= 1'b0;
            err_addr <= '0;
        end else begin
            if (fault && (!err_flag || err_clr))
                err_addr <= addr;
            if (fault)
                err_flag <= 1'b1;
            else if (err_clr)
                err_flag <= 1'b0;
        end
    end
`else
    assign err_flag = 1'b0;
    assign err_addr = '0;
`endif

    assign pend_word = {err_flag, 31'b0} | 32'(pend);

    always_comb begin
        rd_mux = '0;
        case (region)
            REG_DM:  rd_mux = dm_rdata;
            REG_DEV: rd_mux = dev_sel_rdata;
            REG_BRG: begin
                if (brg_off == BRG_PEND_OFF)
                    rd_mux = pend_word;
                else if (brg_off == BRG_MASK_OFF)
                    rd_mux = 32'(mask);
                else if (brg_off == BRG_ERR_OFF)
                    rd_mux = err_addr;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= req && is_load;
            if (req && is_load)
                rdata <= rd_mux;
        end
    end

    assign irq = (|(pend & mask)) | err_flag;

endmodule

// File: tb/tb_sys_bridge_n.sv
// Self-checking bench for sys_bridge_n: directed scenarios plus randomized
// traffic checked against an address-map level reference model.
module tb_sys_bridge_n;

    localparam int          N_DEV      = 2;
    localparam logic [31:0] DEV_BASE   = 32'h7f00;
    localparam logic [31:0] DEV_STRIDE = 32'h10;
    localparam int          DEV_SPAN   = 12;
    localparam logic [31:0] DM_LAST    = 32'h2fff;
    localparam logic [31:0] BRG_BASE   = DEV_BASE + N_DEV * DEV_STRIDE;
`ifdef BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                req;
    logic [31:0]         addr;
    logic [3:0]          byteen;
    logic [31:0]         wdata;
    logic [31:0]         dm_rdata;
    logic [32*N_DEV-1:0] dev_rdata;
    logic [N_DEV-1:0]    dev_irq;
    logic [3:0]          dm_we;
    logic [N_DEV-1:0]    dev_we;
    logic [31:0]         dev_addr;
    logic [31:0]         dev_wdata;
    logic [31:0]         rdata;
    logic                rd_valid;
    logic                irq;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [N_DEV-1:0] m_pend, m_prev, m_mask;
    logic             m_err;
    logic [31:0]      m_err_addr, m_rdata;
    logic             m_rd_valid;

    sys_bridge_n #(
        .N_DEV(N_DEV), .DEV_BASE(DEV_BASE), .DEV_STRIDE(DEV_STRIDE),
        .DEV_SPAN(DEV_SPAN), .DM_LAST(DM_LAST)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .byteen(byteen),
        .wdata(wdata), .dm_rdata(dm_rdata), .dev_rdata(dev_rdata),
        .dev_irq(dev_irq), .dm_we(dm_we), .dev_we(dev_we), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .rdata(rdata), .rd_valid(rd_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int dev_of(input logic [31:0] a);
        logic [31:0] off;
        if (a < DEV_BASE) return -1;
        off = a - DEV_BASE;
        if ((off / DEV_STRIDE) < N_DEV && (off % DEV_STRIDE) < DEV_SPAN)
            return int'(off / DEV_STRIDE);
        return -1;
    endfunction

    function automatic bit is_dm(input logic [31:0] a);
        return a <= DM_LAST;
    endfunction

    function automatic bit is_brg(input logic [31:0] a);
        return a >= BRG_BASE && a < BRG_BASE + 12;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        int k;
        k = dev_of(a);
        if (is_dm(a)) return dm_rdata;
        if (k >= 0) return dev_rdata[32*k +: 32];
        if (is_brg(a)) begin
            case (a - BRG_BASE)
                32'h0: return {m_err, 31'b0} | 32'(m_pend);
                32'h4: return 32'(m_mask);
                32'h8: return m_err_addr;
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    function automatic logic [3:0] exp_dm_we();
        return (req && !reset && is_dm(addr)) ? byteen : 4'h0;
    endfunction

    function automatic logic [N_DEV-1:0] exp_dev_we();
        int k;
        logic [N_DEV-1:0] v;
        v = '0;
        k = dev_of(addr);
        if (req && !reset && byteen == 4'hf && k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_irq();
        return (|(m_pend & m_mask)) | m_err;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
        req       = r;
        addr      = a;
        byteen    = be;
        wdata     = wd;
        dm_rdata  = $urandom;
        dev_rdata = {$urandom, $urandom};
        #1;
    endtask

    // Advance one clock, predicting the model's next state from the inputs
    // present before the edge.
    task automatic step();
        logic [N_DEV-1:0] n_pend, n_mask;
        logic             n_err, n_rdv, fault, brg_wr, err_clr, mapped;
        logic [31:0]      n_err_addr, n_rdata, off;
        int               k;
        if (reset) begin
            n_pend = '0; n_mask = '0; n_err = 1'b0; n_err_addr = '0;
            n_rdata = '0; n_rdv = 1'b0;
        end else begin
            k      = dev_of(addr);
            mapped = is_dm(addr) || k >= 0 || is_brg(addr);
            fault  = req && (!mapped || (!is_dm(addr) && byteen != 4'h0 && byteen != 4'hf));
            brg_wr = req && is_brg(addr) && byteen == 4'hf;
            off    = addr - BRG_BASE;
            n_rdv  = req && byteen == 4'h0;
            n_rdata = n_rdv ? exp_read(addr) : m_rdata;
            for (int j = 0; j < N_DEV; j++) begin
                if (dev_irq[j] && !m_prev[j]) n_pend[j] = 1'b1;
                else if (brg_wr && off == 0 && wdata[j]) n_pend[j] = 1'b0;
                else n_pend[j] = m_pend[j];
            end
            n_mask     = (brg_wr && off == 4) ? wdata[N_DEV-1:0] : m_mask;
            n_err      = m_err;
            n_err_addr = m_err_addr;
            if (ERR_EN) begin
                err_clr = brg_wr && off == 0 && wdata[31];
                if (fault) begin
                    n_err = 1'b1;
                    if (!m_err || err_clr) n_err_addr = addr;
                end else if (err_clr) begin
                    n_err = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        m_prev     = reset ? '0 : dev_irq;
        m_pend     = n_pend;
        m_mask     = n_mask;
        m_err      = n_err;
        m_err_addr = n_err_addr;
        m_rdata    = n_rdata;
        m_rd_valid = n_rdv;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        dev_irq = 2'b01;
        drive(1'b1, 32'h0000_0040, 4'hf, 32'h1234_5678);
        checks++; if (dm_we !== 4'h0) begin errors++; $display("FAIL reset_dm_we: got %h want 0", dm_we); end
        checks++; if (dev_we !== '0) begin errors++; $display("FAIL reset_dev_we: got %b want 0", dev_we); end
        step();
        checks++; if (rd_valid !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL reset_rd: got valid=%b rdata=%h want 0/0", rd_valid, rdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        reset = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 32'h0);
        step();
        // level high at release counts as an edge
        drive(1'b1, BRG_BASE, 4'h0, 32'h0);
        step();
        checks++; if (rdata !== 32'h1 || rdata !== m_rdata) begin errors++; $display("FAIL reset_release_edge: got %h want %h", rdata, 32'h1); end
        drive(1'b1, BRG_BASE, 4'hf, 32'h1);
        step();
        drive(1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_dm();
        logic [31:0] v;
        drive(1'b1, 32'h0000_0100, 4'h3, 32'hdeadbeef);
        checks++; if (dm_we !== 4'h3) begin errors++; $display("FAIL dm_store_we: got %h want 3", dm_we); end
        checks++; if (dev_we !== '0) begin errors++; $display("FAIL dm_store_dev_we: got %b want 0", dev_we); end
        checks++; if (dev_wdata !== 32'hdeadbeef || dev_addr !== 32'h100) begin errors++; $display("FAIL dm_forward: got %h/%h want 00000100/deadbeef", dev_addr, dev_wdata); end
        step();
        drive(1'b1, 32'h0000_0100, 4'h0, 32'h0);
        v = dm_rdata;
        step();
        drive(1'b0, 32'h0, 4'h0, 32'h0);
        checks++; if (rd_valid !== 1'b1 || rdata !== v) begin errors++; $display("FAIL dm_load: got valid=%b rdata=%h want 1/%h", rd_valid, rdata, v); end
        step();
        checks++; if (rd_valid !== 1'b0 || rdata !== v) begin errors++; $display("FAIL dm_hold: got valid=%b rdata=%h want 0/%h", rd_valid, rdata, v); end
    endtask

    task automatic test_dev();
        drive(1'b1, 32'h0000_7f14, 4'hf, 32'h0bad_cafe);
        checks++; if (dev_we !== 2'b10 || dm_we !== 4'h0) begin errors++; $display("FAIL dev_store_we: got dev=%b dm=%h want 10/0", dev_we, dm_we); end
        step();
        drive(1'b1, 32'h0000_7f18, 4'h0, 32'h0);
        dev_rdata[63:32] = 32'h55;
        step();
        drive(1'b0, 32'h0, 4'h0, 32'h0);
        checks++; if (rd_valid !== 1'b1 || rdata !== 32'h55) begin errors++; $display("FAIL dev_load: got valid=%b rdata=%h want 1/00000055", rd_valid, rdata); end
        drive(1'b1, 32'h0000_7f0c, 4'hf, 32'h1);
        checks++; if (dev_we !== '0) begin errors++; $display("FAIL dev_gap_we: got %b want 0", dev_we); end
        step();
    endtask

    task automatic test_fault();
        drive(1'b1, 32'h0000_7f00, 4'h1, 32'hffff_ffff);
        checks++; if (dev_we !== '0) begin errors++; $display("FAIL partial_store_we: got %b want 0", dev_we); end
        step();
        checks++; if (irq !== ERR_EN) begin errors++; $display("FAIL fault_irq: got %b want %b", irq, ERR_EN); end
        drive(1'b1, 32'h0000_7f04, 4'h1, 32'h0);
        step();
        drive(1'b1, BRG_BASE + 8, 4'h0, 32'h0);
        step();
        checks++; if (rdata !== (ERR_EN ? 32'h7f00 : 32'h0)) begin errors++; $display("FAIL err_addr: got %h want %h", rdata, ERR_EN ? 32'h7f00 : 32'h0); end
        drive(1'b1, BRG_BASE, 4'h0, 32'h0);
        step();
        checks++; if (rdata[31] !== ERR_EN || rdata !== m_rdata) begin errors++; $display("FAIL err_pend: got %h want %h", rdata, m_rdata); end
        drive(1'b1, BRG_BASE, 4'hf, 32'h8000_0000);
        step();
        drive(1'b0, 32'h0, 4'h0, 32'h0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL err_clear_irq: got %b want 0", irq); end
    endtask

    task automatic test_irq_mask();
        dev_irq = 2'b00;
        drive(1'b1, BRG_BASE + 4, 4'hf, 32'hffff_fff1);
        step();
        dev_irq = 2'b01;
        drive(1'b0, 32'h0, 4'h0, 32'h0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_edge: got %b want 0", irq); end
        step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_edge: got %b want 1", irq); end
        drive(1'b1, BRG_BASE + 4, 4'h0, 32'h0);
        step();
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL mask_readback: got %h want 00000001", rdata); end
        drive(1'b1, BRG_BASE, 4'hf, 32'h1);
        step();
        drive(1'b1, BRG_BASE, 4'h0, 32'h0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c_held: got %b want 0", irq); end
        step();
        checks++; if (rdata[0] !== 1'b0) begin errors++; $display("FAIL pend_w1c_held: got %h want bit0=0", rdata); end
    endtask

    task automatic test_set_wins();
        dev_irq = 2'b01;
        drive(1'b0, 32'h0, 4'h0, 32'h0);
        step();
        dev_irq = 2'b11;
        drive(1'b1, BRG_BASE, 4'hf, 32'h2);
        step();
        drive(1'b1, BRG_BASE, 4'h0, 32'h0);
        step();
        checks++; if (rdata[1] !== 1'b1 || rdata !== m_rdata) begin errors++; $display("FAIL set_wins: got %h want %h", rdata, m_rdata); end
        dev_irq = 2'b00;
        drive(1'b1, BRG_BASE, 4'hf, 32'hffff_ffff);
        step();
    endtask

    task automatic test_unmapped_reset();
        drive(1'b1, 32'h0000_5000, 4'h0, 32'h0);
        step();
        checks++; if (rd_valid !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL unmapped_load: got valid=%b rdata=%h want 1/0", rd_valid, rdata); end
        drive(1'b1, BRG_BASE + 4, 4'hf, 32'h3);
        step();
        drive(1'b1, BRG_BASE + 4, 4'h0, 32'h0);
        reset = 1'b1;
        #1;
        step();
        checks++; if (rd_valid !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL reset_mid_load: got valid=%b rdata=%h irq=%b want 0/0/0", rd_valid, rdata, irq); end
        reset = 1'b0;
        drive(1'b1, BRG_BASE + 4, 4'h0, 32'h0);
        step();
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mask_after_reset: got %h want 0", rdata); end
        drive(1'b1, BRG_BASE + 8, 4'h0, 32'h0);
        step();
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL erraddr_after_reset: got %h want 0", rdata); end
    endtask

    task automatic test_random();
        logic [31:0] a, wd;
        logic [3:0]  be;
        logic        r;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: a = {18'h0, 12'($urandom_range(0, 12'hbff)), 2'b00};
                1: a = DEV_BASE + DEV_STRIDE * $urandom_range(0, N_DEV - 1) + 4 * $urandom_range(0, 2);
                2: a = BRG_BASE + 4 * $urandom_range(0, 2);
                default: begin
                    case ($urandom_range(0, 4))
                        0: a = DM_LAST + 1;
                        1: a = 32'h0000_5000;
                        2: a = DEV_BASE + 12;
                        3: a = BRG_BASE + 12;
                        default: a = 32'hffff_fff0;
                    endcase
                end
            endcase
            case ($urandom_range(0, 3))
                0: be = 4'h0;
                1: be = 4'hf;
                default: be = 4'($urandom_range(0, 15));
            endcase
            r  = ($urandom_range(0, 3) != 0);
            wd = $urandom;
            if ($urandom_range(0, 2) == 0) dev_irq = N_DEV'($urandom);
            reset = ($urandom_range(0, 59) == 0);
            drive(r, a, be, wd);
            checks++; if (dm_we !== exp_dm_we()) begin errors++; $display("FAIL rand_dm_we[%0d]: got %h want %h", i, dm_we, exp_dm_we()); end
            checks++; if (dev_we !== exp_dev_we()) begin errors++; $display("FAIL rand_dev_we[%0d]: got %b want %b", i, dev_we, exp_dev_we()); end
            step();
            checks++; if (rd_valid !== m_rd_valid || rdata !== m_rdata) begin errors++; $display("FAIL rand_read[%0d]: got valid=%b rdata=%h want %b/%h", i, rd_valid, rdata, m_rd_valid, m_rdata); end
            checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL rand_irq[%0d]: got %b want %b", i, irq, exp_irq()); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; addr = '0; byteen = '0; wdata = '0;
        dm_rdata = '0; dev_rdata = '0; dev_irq = '0;
        m_pend = '0; m_prev = '0; m_mask = '0; m_err = 1'b0;
        m_err_addr = '0; m_rdata = '0; m_rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_dm();
        test_dev();
        test_fault();
        test_irq_mask();
        test_set_wins();
        test_unmapped_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_bridge_n.md
# sys_bridge_n

Parametrised memory-mapped bridge between the CPU's M-stage data port and data memory plus N peripheral devices. Decodes address and byte-enables into per-device write strobes and a registered read-data mux. Adds an in-bridge control window with sticky, maskable interrupt pending bits and unmapped-access error capture. Sits between the M-stage and DM/timers; its `irq` output feeds CP0.

## Interface
Parameters:
- N_DEV, 2, number of peripheral windows (1..8)
- DEV_BASE, 32'h7f00, base address of device 0
- DEV_STRIDE, 32'h10, byte spacing between device windows
- DEV_SPAN, 12, bytes decoded per device window (3 words)
- DM_LAST, 32'h2fff, last byte address of data memory (DM starts at 0)

Ports:
- clk  in  1  system clock; one clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  M-stage load/store valid this cycle
- addr  in  32  byte address, word aligned
- byteen  in  4  store byte enables; 4'h0 = load
- wdata  in  32  store data
- dm_rdata  in  32  DM read data (combinational for `addr`)
- dev_rdata  in  32*N_DEV  device read data, device k in bits [32k+31:32k]
- dev_irq  in  N_DEV  device interrupt levels
- dm_we  out  4  DM byte write enables
- dev_we  out  N_DEV  one-hot device write strobe
- dev_addr / dev_wdata  out  32  forwarded addr/wdata
- rdata  out  32  registered read data
- rd_valid  out  1  rdata valid (one cycle after load req)
- irq  out  1  OR of pending & mask (& error if enabled)

## Operation
- Regions: DM = [0, DM_LAST]; device k = [DEV_BASE + k*DEV_STRIDE, +DEV_SPAN-1]; bridge control BRG = DEV_BASE + N_DEV*DEV_STRIDE, 3 words; everything else unmapped.
- BRG registers: +0 PEND (read; write-1-to-clear), +4 MASK (R/W, bits [N_DEV-1:0]), +8 ERR_ADDR (read-only, last faulting address).
- Stores: DM takes any byteen; device/BRG windows accept only byteen==4'hf. Partial stores to device/BRG, and any access to unmapped space, are faults: no strobe, data dropped.
- Strobes only when req=1; dm_we = byteen when in DM, else 0.
- Loads: selected source captured into rdata on the clock edge; unmapped/fault loads return 32'h0.
- Interrupt capture: per channel, rising edge of dev_irq[k] (vs. previous-cycle sample) sets PEND[k]. Same-cycle set and W1C clear → set wins.
- irq = |(PEND & MASK[N_DEV-1:0]).
- Bits of PEND/MASK above N_DEV-1 read 0, writes ignored.

## Timing
- Write path combinational: dm_we/dev_we asserted in the request cycle.
- Read latency 1: rd_valid high in cycle after req with byteen==0; rdata holds until next load.
- PEND set visible in cycle after edge; irq visible same cycle as PEND.
- MASK write effective next cycle.
- Reset: rdata=0, rd_valid=0, PEND=0, MASK=0, ERR_ADDR=0, err flag=0, edge sample=0; dm_we/dev_we=0 while reset high. A dev_irq level already high at reset release is an edge on the first post-reset cycle.
- Reset mid-transaction drops any in-flight read (rd_valid=0 next cycle).

## Configuration
- BRIDGE_ERR_EN defined: fault latches ERR_ADDR=addr and sets sticky err flag (PEND bit 31, W1C); irq also ORs err flag (unmaskable). First fault after clear wins; later faults do not overwrite ERR_ADDR while flag set.
- Undefined: faults silently dropped; ERR_ADDR and PEND[31] read 0.

## Structure
- Package `bridge_pkg`: BRG register offsets, DEV_SPAN/STRIDE defaults, region-select enum (DM, DEV, BRG, NONE), err bit index 31.
- Sub-module `irq_edge_latch`: per-channel edge detect + sticky W1C pending bit, instantiated N_DEV times.

## Test plan
- Store 32'hdeadbeef, byteen 4'h3, to 0x0100 → dm_we=4'h3 same cycle, dev_we=0; load 0x0100 → rd_valid next cycle, rdata=dm_rdata.
- N_DEV=2: store full word to 0x7f14 → dev_we=2'b10; load 0x7f18 with dev_rdata[63:32]=32'h55 → rdata=32'h55 next cycle.
- Store byteen 4'h1 to 0x7f00 → dev_we=0; with BRIDGE_ERR_EN ERR_ADDR=0x7f00, PEND[31]=1, irq=1.
- dev_irq[0] 0→1, MASK=1 → PEND[0]=1 next cycle, irq=1; W1C PEND=1 while dev_irq held high → PEND[0]=0, irq=0.
- W1C of PEND[1] in same cycle as dev_irq[1] rising → PEND[1]=1.
- Load from 0x5000 → rdata=0; assert reset during load → rd_valid=0, all registers 0 next cycle.
